mem_access_ctrl: RTL and testbench

Initiator side of the data-memory req/ack interface. It sits between the MIPS load/store pipeline stage and the word-addressed data memory. It converts byte, half and word loads/stores into single-cycle memory request pulses, doing read-modify-write for sub-word stores. It also performs sign/zero extension and alignment checks, and aborts on a missing ack.

---
 rtl/mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Initiator side of the data-memory req/ack interface. Sits between the
// load/store pipeline stage and a word-addressed data memory. Turns byte,
// half and word loads/stores into single-cycle memory request pulses.
// Sub-word stores are done as a read-modify-write. Load data is sign- or
// zero-extended. Misaligned accesses, the illegal size code and a missing
// ack are all reported through cpu_err.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   cpu_req       : access request, sampled only while idle
//   cpu_we        : 1 = store, 0 = load
//   cpu_size      : 00 byte, 01 half, 10 word, 11 illegal
//   cpu_unsigned  : 1 = zero-extend loads, 0 = sign-extend
//   cpu_addr      : byte address
//   cpu_wdata     : store data, right-justified for sub-word stores
//   cpu_busy      : high whenever the controller is not idle
//   cpu_done      : one-cycle completion pulse
//   cpu_err       : error flag, valid with cpu_done
//   cpu_rdata     : extended load result, valid with cpu_done
//   mem_req       : one-cycle request pulse to memory
//   mem_we        : memory write enable, qualifies mem_req
//   mem_addr      : word-aligned memory address
//   mem_wdata     : full-word write data
//   mem_ack       : registered ack, one cycle after the sampled request
//   mem_rdata     : read word, valid while mem_ack is high

module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    ERR
  } state_e;

  localparam logic [1:0]       SIZE_BYTE = 2'b00;
  localparam logic [1:0]       SIZE_HALF = 2'b01;
  localparam logic [1:0]       SIZE_WORD = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic              storeWe_q, storeWe_d;
  logic [1:0]        size_q, size_d;
  logic              unsignedLd_q, unsignedLd_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cpuDone_q, cpuDone_d;
  logic              cpuErr_q, cpuErr_d;
  logic [31:0]       cpuRdata_q, cpuRdata_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [31:0]       memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;

  logic              misaligned;
  logic              needsRead;
  logic [7:0]        byteField;
  logic [15:0]       halfField;
  logic [31:0]       loadExt;
  logic [31:0]       mergedWord;

  assign cpu_busy  = (state_q != IDLE);
  assign cpu_done  = cpuDone_q;
  assign cpu_err   = cpuErr_q;
  assign cpu_rdata = cpuRdata_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

  // Request-time decode, evaluated on the live cpu_* inputs while idle.
  // Loads and sub-word stores both start with a read.
  always_comb begin
    misaligned = 1'b0;
    case (cpu_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = cpu_addr[0];
      SIZE_WORD: misaligned = (cpu_addr[1:0] != 2'b00);
      default:   misaligned = 1'b1;
    endcase
    needsRead = !cpu_we || (cpu_size != SIZE_WORD);
  end

  // Lane extraction and extension of the returned word for loads, and the
  // merge of the latched store data into that word for sub-word stores.
  // Little-endian: byte lane = addr[1:0], half lane = addr[1].
  always_comb begin
    byteField = mem_rdata[{lane_q, 3'b000} +: 8];
    halfField = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadExt   = mem_rdata;
    case (size_q)
      SIZE_BYTE: loadExt = unsignedLd_q ? {24'h0, byteField}
                                        : {{24{byteField[7]}}, byteField};
      SIZE_HALF: loadExt = unsignedLd_q ? {16'h0, halfField}
                                        : {{16{halfField[15]}}, halfField};
      default:   loadExt = mem_rdata;
    endcase

    mergedWord = mem_rdata;
    case (size_q)
      SIZE_BYTE: mergedWord[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      SIZE_HALF: begin
        if (lane_q[1]) begin
          mergedWord[31:16] = wdata_q;
        end else begin
          mergedWord[15:0] = wdata_q;
        end
      end
      default:   mergedWord = mem_rdata;
    endcase
  end

  // Next-state logic. mem_req/mem_we are registered, so they are raised
  // on the transition into RD or WR and drop automatically one cycle later,
  // which keeps mem_req from ever being high two cycles running. The wait
  // counter is cleared on the way into each wait state; ack takes priority
  // over the timeout limit when both happen in the same cycle.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    storeWe_d    = storeWe_q;
    size_d       = size_q;
    unsignedLd_d = unsignedLd_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    cpuDone_d    = 1'b0;
    cpuErr_d     = 1'b0;
    cpuRdata_d   = cpuRdata_q;
    memReq_d     = 1'b0;
    memWe_d      = 1'b0;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          storeWe_d    = cpu_we;
          size_d       = cpu_size;
          unsignedLd_d = cpu_unsigned;
          lane_d       = cpu_addr[1:0];
          wdata_d      = cpu_wdata[15:0];
          if (misaligned) begin
            // Error is reported in the very next cycle, without touching memory.
            state_d    = ERR;
            cpuDone_d  = 1'b1;
            cpuErr_d   = 1'b1;
            cpuRdata_d = 32'h0;
          end else if (needsRead) begin
            state_d   = RD;
            memReq_d  = 1'b1;
            memAddr_d = {cpu_addr[31:2], 2'b00};
          end else begin
            state_d    = WR;
            memReq_d   = 1'b1;
            memWe_d    = 1'b1;
            memAddr_d  = {cpu_addr[31:2], 2'b00};
            memWdata_d = cpu_wdata;
          end
        end
      end

      RD: begin
        state_d   = RD_WAIT;
        waitCnt_d = '0;
      end

      RD_WAIT: begin
        if (mem_ack) begin
          if (storeWe_q) begin
            state_d    = WR;
            memReq_d   = 1'b1;
            memWe_d    = 1'b1;
            memWdata_d = mergedWord;
          end else begin
            state_d    = IDLE;
            cpuDone_d  = 1'b1;
            cpuRdata_d = loadExt;
          end
        end else if (waitCnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cpuDone_d  = 1'b1;
          cpuErr_d   = 1'b1;
          cpuRdata_d = 32'h0;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end

      WR: begin
        state_d   = WR_WAIT;
        waitCnt_d = '0;
      end

      WR_WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          cpuDone_d = 1'b1;
        end else if (waitCnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cpuDone_d  = 1'b1;
          cpuErr_d   = 1'b1;
          cpuRdata_d = 32'h0;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      storeWe_q    <= 1'b0;
      size_q       <= 2'b00;
      unsignedLd_q <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      cpuDone_q    <= 1'b0;
      cpuErr_q     <= 1'b0;
      cpuRdata_q   <= 32'h0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= 32'h0;
      memWdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      storeWe_q    <= storeWe_d;
      size_q       <= size_d;
      unsignedLd_q <= unsignedLd_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      cpuDone_q    <= cpuDone_d;
      cpuErr_q     <= cpuErr_d;
      cpuRdata_q   <= cpuRdata_d;
      memReq_q     <= memReq_d;
      memWe_q      <= memWe_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// ------------------
// Directed bench for mem_access_ctrl. A small word-addressed memory model
// answers each sampled request with a registered ack one cycle later and can
// be told to stop acking. Every access is timed in cycles from the cycle in
// which cpu_req is presented (cycle 0).

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:63];
  logic        ackEnable = 1'b1;

  int          checks = 0;
  int          failures = 0;
  int          b2bViolations = 0;

  int          obsDoneCycle;
  int          obsReqCount;
  logic        obsErr;
  logic [31:0] obsRdata;

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered ack and read data one cycle after a sampled
  // request; writes land at the same edge the request is sampled.
  always @(posedge clk) begin
    mem_ack <= mem_req && ackEnable;
    if (mem_req && ackEnable) begin
      mem_rdata <= mem[mem_addr[7:2]];
      if (mem_we) begin
        mem[mem_addr[7:2]] <= mem_wdata;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one access in cycle 0, then watches up to 40 cycles for
  // cpu_done, counting mem_req pulses along the way. cpu_* inputs are
  // scrambled after acceptance to show they are no longer looked at.
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata);
    logic prevReq;
    @(negedge clk);
    cpu_we       = we;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    cpu_req      = 1'b1;
    @(posedge clk);
    #1;
    cpu_req      = 1'b0;
    cpu_we       = ~we;
    cpu_size     = 2'b11;
    cpu_unsigned = ~uns;
    cpu_addr     = 32'hFFFF_FFFF;
    cpu_wdata    = 32'h5A5A_5A5A;
    obsDoneCycle = -1;
    obsReqCount  = 0;
    obsErr       = 1'bx;
    obsRdata     = 32'hx;
    prevReq      = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_req) begin
        obsReqCount++;
        if (prevReq) b2bViolations++;
      end
      prevReq = mem_req;
      if (cpu_done) begin
        obsDoneCycle = k;
        obsErr       = cpu_err;
        obsRdata     = cpu_rdata;
        break;
      end
    end
  endtask

  initial begin
    int quietReq;
    int quietDone;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy",  32'(cpu_busy),  32'h0);
    checkOutput("rst_done",  32'(cpu_done),  32'h0);
    checkOutput("rst_err",   32'(cpu_err),   32'h0);
    checkOutput("rst_req",   32'(mem_req),   32'h0);
    checkOutput("rst_rdata", cpu_rdata,      32'h0);
    checkOutput("rst_maddr", mem_addr,       32'h0);
    rst = 1'b0;

    // Word store then load at 0x10
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checkOutput("wst_done_cyc", 32'(obsDoneCycle), 32'd3);
    checkOutput("wst_err",      32'(obsErr),       32'h0);
    checkOutput("wst_reqs",     32'(obsReqCount),  32'd1);
    checkOutput("wst_mem",      mem[4],            32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("wld_done_cyc", 32'(obsDoneCycle), 32'd3);
    checkOutput("wld_rdata",    obsRdata,          32'hDEAD_BEEF);
    checkOutput("wld_err",      32'(obsErr),       32'h0);

    // Byte store read-modify-write at 0x22
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB);
    checkOutput("bst_done_cyc", 32'(obsDoneCycle), 32'd5);
    checkOutput("bst_reqs",     32'(obsReqCount),  32'd2);
    checkOutput("bst_err",      32'(obsErr),       32'h0);
    checkOutput("bst_mem",      mem[8],            32'h11AB_3344);

    // Half store into the upper half of the same word
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_5566);
    checkOutput("hst_done_cyc", 32'(obsDoneCycle), 32'd5);
    checkOutput("hst_mem",      mem[8],            32'h5566_3344);

    // Extension cases on 0x80FF7F01 at 0x30
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF_7F01);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h32, 32'h0);
    checkOutput("ld_sb32",      obsRdata,          32'hFFFF_FFFF);
    checkOutput("ld_sb32_cyc",  32'(obsDoneCycle), 32'd3);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    checkOutput("ld_uh32",      obsRdata,          32'h0000_80FF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
    checkOutput("ld_sh30",      obsRdata,          32'h0000_7F01);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    checkOutput("ld_sh32",      obsRdata,          32'hFFFF_80FF);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h33, 32'h0);
    checkOutput("ld_ub33",      obsRdata,          32'h0000_0080);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
    checkOutput("ld_sb31",      obsRdata,          32'h0000_007F);

    // Misaligned and illegal-size accesses
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h31, 32'h0);
    checkOutput("mis_wld_cyc",  32'(obsDoneCycle), 32'd1);
    checkOutput("mis_wld_err",  32'(obsErr),       32'h1);
    checkOutput("mis_wld_rd",   obsRdata,          32'h0);
    checkOutput("mis_wld_reqs", 32'(obsReqCount),  32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000_1234);
    checkOutput("mis_hst_cyc",  32'(obsDoneCycle), 32'd1);
    checkOutput("mis_hst_err",  32'(obsErr),       32'h1);
    checkOutput("mis_hst_reqs", 32'(obsReqCount),  32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h30, 32'h0000_0000);
    checkOutput("ill_sz_cyc",   32'(obsDoneCycle), 32'd1);
    checkOutput("ill_sz_err",   32'(obsErr),       32'h1);
    checkOutput("ill_sz_reqs",  32'(obsReqCount),  32'd0);
    checkOutput("mis_mem",      mem[12],           32'h80FF_7F01);

    // Timeout: RD_WAIT entered in cycle 2, abort reported 16 cycles later
    ackEnable = 1'b0;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("to_done_cyc",  32'(obsDoneCycle), 32'd18);
    checkOutput("to_err",       32'(obsErr),       32'h1);
    checkOutput("to_reqs",      32'(obsReqCount),  32'd1);
    ackEnable = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    checkOutput("post_to_cyc",  32'(obsDoneCycle), 32'd3);
    checkOutput("post_to_rd",   obsRdata,          32'h80FF_7F01);
    checkOutput("post_to_err",  32'(obsErr),       32'h0);

    // Reset in RD_WAIT of a byte store to 0x20
    @(negedge clk);
    cpu_we   = 1'b1;
    cpu_size = 2'b00;
    cpu_addr = 32'h20;
    cpu_wdata = 32'h0000_0099;
    cpu_req  = 1'b1;
    @(posedge clk);
    #1;
    cpu_req  = 1'b0;
    @(negedge clk);
    checkOutput("rmw_rst_req1", 32'(mem_req), 32'h1);
    @(negedge clk);
    checkOutput("rmw_rst_busy_w", 32'(cpu_busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rmw_rst_busy", 32'(cpu_busy), 32'h0);
    checkOutput("rmw_rst_done", 32'(cpu_done), 32'h0);
    checkOutput("rmw_rst_req",  32'(mem_req),  32'h0);
    rst = 1'b0;
    quietReq  = 0;
    quietDone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req)  quietReq++;
      if (cpu_done) quietDone++;
    end
    checkOutput("rmw_rst_quiet_req",  32'(quietReq),  32'd0);
    checkOutput("rmw_rst_quiet_done", 32'(quietDone), 32'd0);
    checkOutput("rmw_rst_mem",        mem[8],         32'h5566_3344);

    checkOutput("req_b2b", 32'(b2bViolations), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
